// File: rtl/mjpeg_ddr3_writer.sv
// mjpeg_ddr3_writer: packs the MJPEG encoder byte stream into DATA_W-bit
// beats, queues them in a beat FIFO and issues single-beat DDR3 writes into a
// per-frame bank that rotates over NUM_BANKS. Completed frames report their
// bank and byte length to the read side.
// Optional build macro MJPEG_WR_PARTIAL_MASK_EN: mask the unused low lanes of
// a partial last beat instead of writing them as zeros.
module mjpeg_ddr3_writer #(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned ADDR_STEP  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_frame_start,
    input  logic                  i_byte_de,
    input  logic [7:0]            i_byte_data,
    input  logic                  i_frame_end,
    output logic [2:0]            o_ddr3_cmd,
    output logic                  o_ddr3_cmd_en,
    output logic [27:0]           o_ddr3_addr,
    output logic [DATA_W-1:0]     o_ddr3_wr_data,
    output logic                  o_ddr3_wr_data_en,
    output logic                  o_ddr3_wr_data_end,
    output logic [DATA_W/8-1:0]   o_ddr3_wr_mask,
    input  logic                  i_ddr3_cmd_ready,
    input  logic                  i_ddr3_wr_data_rdy,
    output logic                  o_frame_done,
    output logic [2:0]            o_frame_bank,
    output logic [23:0]           o_frame_len,
    output logic                  o_overflow,
    output logic                  o_busy
);

    localparam int unsigned BPB       = DATA_W / 8;
    localparam int unsigned CW        = $clog2(BPB + 1);
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [23:0] STEP      = 24'(ADDR_STEP);
    localparam logic [2:0]  LAST_BANK = 3'(NUM_BANKS - 1);
`ifdef MJPEG_WR_PARTIAL_MASK_EN
    localparam int unsigned FW        = DATA_W + BPB;
    localparam logic [BPB-1:0] MASK_ONES = '1;
`else
    localparam int unsigned FW        = DATA_W;
`endif

    typedef enum logic [1:0] {F_IDLE, F_RUN, F_FLUSH, F_DONE} frame_state_t;
    typedef enum logic {W_IDLE, W_ISSUE} wr_state_t;

    frame_state_t frame_state_q, frame_state_d;
    wr_state_t    w_state_q, w_state_d;

    logic [DATA_W-1:0] pack_data_q, pack_data_d;
    logic [CW-1:0]     pack_cnt_q, pack_cnt_d;
    logic              push_vld_q, push_vld_d;
    logic [DATA_W-1:0] push_data_q, push_data_d;
    logic [23:0]       byte_cnt_q, byte_cnt_d;
    logic              overflow_q, overflow_d;
    logic [2:0]        bank_q, bank_d;
    logic [23:0]       row_col_q, row_col_d;
    logic [2:0]        frame_bank_q, frame_bank_d;
    logic [23:0]       frame_len_q, frame_len_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              issued_q, issued_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
`ifdef MJPEG_WR_PARTIAL_MASK_EN
    logic [BPB-1:0]    push_mask_q, push_mask_d;
    logic [BPB-1:0]    wr_mask_q, wr_mask_d;
`endif

    logic [FW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [FW-1:0]     fifo_head;
    logic [FW-1:0]     fifo_wdata;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_wr;
    logic              frame_start_acc;

    logic [DATA_W-1:0] packed_beat;
    logic [CW-1:0]     fill;

    assign fifo_empty      = (wr_ptr_q == rd_ptr_q);
    assign fifo_full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                             (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_wr         = push_vld_q && !fifo_full;
    assign fifo_head       = fifo_mem[rd_ptr_q[AW-1:0]];
    assign frame_start_acc = (frame_state_q == F_IDLE) && i_frame_start;
`ifdef MJPEG_WR_PARTIAL_MASK_EN
    assign fifo_wdata      = {push_mask_q, push_data_q};
`else
    assign fifo_wdata      = push_data_q;
`endif

    // Beat storage; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= fifo_wdata;
        end
    end

    // Frame FSM, byte packer, byte counter, overflow flag and bank rotation.
    always_comb begin
        frame_state_d = frame_state_q;
        pack_data_d   = pack_data_q;
        pack_cnt_d    = pack_cnt_q;
        push_vld_d    = 1'b0;
        push_data_d   = push_data_q;
        byte_cnt_d    = byte_cnt_q;
        overflow_d    = overflow_q;
        bank_d        = bank_q;
        frame_bank_d  = frame_bank_q;
        frame_len_d   = frame_len_q;
        packed_beat   = pack_data_q;
        fill          = pack_cnt_q;
`ifdef MJPEG_WR_PARTIAL_MASK_EN
        push_mask_d   = push_mask_q;
`endif

        if (push_vld_q && fifo_full) begin
            overflow_d = 1'b1;
        end

        unique case (frame_state_q)
            F_IDLE: begin
                if (i_frame_start) begin
                    frame_state_d = F_RUN;
                    pack_data_d   = '0;
                    pack_cnt_d    = '0;
                    byte_cnt_d    = '0;
                    overflow_d    = 1'b0;
                end
            end
            F_RUN: begin
                if (i_byte_de) begin
                    for (int unsigned i = 0; i < BPB; i++) begin
                        if (pack_cnt_q == CW'(i)) begin
                            packed_beat[DATA_W-1-8*i -: 8] = i_byte_data;
                        end
                    end
                    fill = pack_cnt_q + CW'(1);
                    if (byte_cnt_q != 24'hFF_FFFF) begin
                        byte_cnt_d = byte_cnt_q + 24'd1;
                    end
                end
                if ((fill == CW'(BPB)) || (i_frame_end && (fill != '0))) begin
                    push_vld_d  = 1'b1;
                    push_data_d = packed_beat;
`ifdef MJPEG_WR_PARTIAL_MASK_EN
                    push_mask_d = MASK_ONES >> fill;
`endif
                    pack_data_d = '0;
                    pack_cnt_d  = '0;
                end else begin
                    pack_data_d = packed_beat;
                    pack_cnt_d  = fill;
                end
                if (i_frame_end) begin
                    frame_state_d = F_FLUSH;
                end
            end
            F_FLUSH: begin
                // issued_q holds completion back one cycle after the last
                // issue so the controller sees the final beat settle first.
                if (!push_vld_q && fifo_empty && (w_state_q == W_IDLE) && !issued_q) begin
                    frame_state_d = F_DONE;
                    frame_bank_d  = bank_q;
                    frame_len_d   = byte_cnt_q;
                    bank_d        = (bank_q == LAST_BANK) ? 3'd0 : bank_q + 3'd1;
                end
            end
            F_DONE: begin
                frame_state_d = F_IDLE;
            end
            default: begin
                frame_state_d = F_IDLE;
            end
        endcase
    end

    // Writer FSM, FIFO pointers and row/column address.
    always_comb begin
        w_state_d = w_state_q;
        wr_data_d = wr_data_q;
        row_col_d = row_col_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        issued_d  = (w_state_q == W_ISSUE);
`ifdef MJPEG_WR_PARTIAL_MASK_EN
        wr_mask_d = wr_mask_q;
`endif

        if (fifo_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        unique case (w_state_q)
            W_IDLE: begin
                if (!fifo_empty && i_ddr3_cmd_ready && i_ddr3_wr_data_rdy) begin
                    w_state_d = W_ISSUE;
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    wr_data_d = fifo_head[DATA_W-1:0];
`ifdef MJPEG_WR_PARTIAL_MASK_EN
                    wr_mask_d = fifo_head[FW-1:DATA_W];
`endif
                end
            end
            W_ISSUE: begin
                w_state_d = W_IDLE;
                row_col_d = row_col_q + STEP;
            end
        endcase

        if (frame_start_acc) begin
            row_col_d = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_state_q <= F_IDLE;
            w_state_q     <= W_IDLE;
            pack_data_q   <= '0;
            pack_cnt_q    <= '0;
            push_vld_q    <= 1'b0;
            push_data_q   <= '0;
            byte_cnt_q    <= '0;
            overflow_q    <= 1'b0;
            bank_q        <= '0;
            row_col_q     <= '0;
            frame_bank_q  <= '0;
            frame_len_q   <= '0;
            wr_data_q     <= '0;
            issued_q      <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
`ifdef MJPEG_WR_PARTIAL_MASK_EN
            push_mask_q   <= '0;
            wr_mask_q     <= '0;
`endif
        end else begin
            frame_state_q <= frame_state_d;
            w_state_q     <= w_state_d;
            pack_data_q   <= pack_data_d;
            pack_cnt_q    <= pack_cnt_d;
            push_vld_q    <= push_vld_d;
            push_data_q   <= push_data_d;
            byte_cnt_q    <= byte_cnt_d;
            overflow_q    <= overflow_d;
            bank_q        <= bank_d;
            row_col_q     <= row_col_d;
            frame_bank_q  <= frame_bank_d;
            frame_len_q   <= frame_len_d;
            wr_data_q     <= wr_data_d;
            issued_q      <= issued_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
`ifdef MJPEG_WR_PARTIAL_MASK_EN
            push_mask_q   <= push_mask_d;
            wr_mask_q     <= wr_mask_d;
`endif
        end
    end

    assign o_ddr3_cmd         = 3'd0;
    assign o_ddr3_cmd_en      = (w_state_q == W_ISSUE);
    assign o_ddr3_wr_data_en  = (w_state_q == W_ISSUE);
    assign o_ddr3_wr_data_end = (w_state_q == W_ISSUE);
    assign o_ddr3_addr        = {1'b0, bank_q, row_col_q};
    assign o_ddr3_wr_data     = wr_data_q;
`ifdef MJPEG_WR_PARTIAL_MASK_EN
    assign o_ddr3_wr_mask     = wr_mask_q;
`else
    assign o_ddr3_wr_mask     = '0;
`endif
    assign o_frame_done       = (frame_state_q == F_DONE);
    assign o_frame_bank       = frame_bank_q;
    assign o_frame_len        = frame_len_q;
    assign o_overflow         = overflow_q;
    assign o_busy             = (frame_state_q != F_IDLE);

endmodule

// File: tb/tb_mjpeg_ddr3_writer.sv
// Directed testbench for mjpeg_ddr3_writer at DATA_W=128, FIFO_DEPTH=16,
// NUM_BANKS=4, ADDR_STEP=8.
`timescale 1ns/1ps
module tb_mjpeg_ddr3_writer;

    localparam int DW = 128;

`ifdef MJPEG_WR_PARTIAL_MASK_EN
    localparam logic [15:0] M20 = 16'h0FFF;
    localparam logic [15:0] M1  = 16'h7FFF;
`else
    localparam logic [15:0] M20 = 16'h0000;
    localparam logic [15:0] M1  = 16'h0000;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_frame_start;
    logic          i_byte_de;
    logic [7:0]    i_byte_data;
    logic          i_frame_end;
    logic [2:0]    o_ddr3_cmd;
    logic          o_ddr3_cmd_en;
    logic [27:0]   o_ddr3_addr;
    logic [DW-1:0] o_ddr3_wr_data;
    logic          o_ddr3_wr_data_en;
    logic          o_ddr3_wr_data_end;
    logic [15:0]   o_ddr3_wr_mask;
    logic          i_ddr3_cmd_ready;
    logic          i_ddr3_wr_data_rdy;
    logic          o_frame_done;
    logic [2:0]    o_frame_bank;
    logic [23:0]   o_frame_len;
    logic          o_overflow;
    logic          o_busy;

    mjpeg_ddr3_writer #(
        .DATA_W    (128),
        .FIFO_DEPTH(16),
        .NUM_BANKS (4),
        .ADDR_STEP (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_frame_start     (i_frame_start),
        .i_byte_de         (i_byte_de),
        .i_byte_data       (i_byte_data),
        .i_frame_end       (i_frame_end),
        .o_ddr3_cmd        (o_ddr3_cmd),
        .o_ddr3_cmd_en     (o_ddr3_cmd_en),
        .o_ddr3_addr       (o_ddr3_addr),
        .o_ddr3_wr_data    (o_ddr3_wr_data),
        .o_ddr3_wr_data_en (o_ddr3_wr_data_en),
        .o_ddr3_wr_data_end(o_ddr3_wr_data_end),
        .o_ddr3_wr_mask    (o_ddr3_wr_mask),
        .i_ddr3_cmd_ready  (i_ddr3_cmd_ready),
        .i_ddr3_wr_data_rdy(i_ddr3_wr_data_rdy),
        .o_frame_done      (o_frame_done),
        .o_frame_bank      (o_frame_bank),
        .o_frame_len       (o_frame_len),
        .o_overflow        (o_overflow),
        .o_busy            (o_busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed writes and frame completions, sampled on the falling edge.
    logic [27:0]   wq_addr [$];
    logic [DW-1:0] wq_data [$];
    logic [15:0]   wq_mask [$];
    int unsigned   wq_cyc  [$];
    logic [2:0]    fd_bank [$];
    logic [23:0]   fd_len  [$];
    logic          fd_ovf  [$];
    int unsigned   fd_cyc  [$];
    int unsigned   strobe_bad = 0;

    always @(negedge clk) begin
        if (o_ddr3_cmd_en) begin
            wq_addr.push_back(o_ddr3_addr);
            wq_data.push_back(o_ddr3_wr_data);
            wq_mask.push_back(o_ddr3_wr_mask);
            wq_cyc.push_back(cyc);
        end
        if ((o_ddr3_wr_data_en != o_ddr3_cmd_en) || (o_ddr3_wr_data_end != o_ddr3_cmd_en) ||
            (o_ddr3_cmd != 3'd0)) begin
            strobe_bad <= strobe_bad + 1;
        end
        if (o_frame_done) begin
            fd_bank.push_back(o_frame_bank);
            fd_len.push_back(o_frame_len);
            fd_ovf.push_back(o_overflow);
            fd_cyc.push_back(cyc);
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ramp(input logic [7:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[DW-1-8*k -: 8] = b + 8'(k);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wq_addr.delete(); wq_data.delete(); wq_mask.delete(); wq_cyc.delete();
        fd_bank.delete(); fd_len.delete(); fd_ovf.delete(); fd_cyc.delete();
    endtask

    task automatic idle_inputs();
        i_frame_start = 1'b0;
        i_byte_de     = 1'b0;
        i_byte_data   = 8'h00;
        i_frame_end   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    int unsigned t_b15;
    int unsigned t_fe;
    int unsigned t_start;

    task automatic start_frame();
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
    endtask

    task automatic send_bytes(input int n, input logic [7:0] base, input bit end_last, input int dup_at);
        for (int i = 0; i < n; i++) begin
            i_byte_de     = 1'b1;
            i_byte_data   = base + 8'(i);
            i_frame_end   = end_last && (i == n - 1);
            i_frame_start = (i == dup_at);
            if (i == 15) t_b15 = cyc;
            if (i_frame_end) t_fe = cyc;
            step();
        end
        idle_inputs();
    endtask

    task automatic end_frame();
        i_frame_end = 1'b1;
        t_fe = cyc;
        step();
        i_frame_end = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while ((fd_bank.size() < n) && (k < budget)) begin
            step();
            k++;
        end
        check("frame_done_seen", DW'(fd_bank.size()), DW'(n));
    endtask

    initial begin
        rst_n              = 1'b0;
        i_ddr3_cmd_ready   = 1'b1;
        i_ddr3_wr_data_rdy = 1'b1;
        idle_inputs();
        do_reset();

        // Reset state
        check("rst_busy",     DW'(o_busy), DW'(0));
        check("rst_cmd_en",   DW'(o_ddr3_cmd_en), DW'(0));
        check("rst_addr",     DW'(o_ddr3_addr), DW'(0));
        check("rst_wr_data",  o_ddr3_wr_data, '0);
        check("rst_overflow", DW'(o_overflow), DW'(0));
        check("rst_len",      DW'(o_frame_len), DW'(0));
        check("rst_done",     DW'(o_frame_done), DW'(0));

        // 32 ascending bytes, frame_end one cycle after the last byte
        clear_logs();
        start_frame();
        send_bytes(32, 8'h00, 1'b0, -1);
        end_frame();
        wait_frames(1, 200);
        check("t1_nwrites", DW'(wq_addr.size()), DW'(2));
        check("t1_addr0",   DW'(wq_addr[0]), DW'(28'h000_0000));
        check("t1_data0",   wq_data[0], 128'h000102030405060708090a0b0c0d0e0f);
        check("t1_addr1",   DW'(wq_addr[1]), DW'(28'h000_0008));
        check("t1_data1",   wq_data[1], 128'h101112131415161718191a1b1c1d1e1f);
        check("t1_mask1",   DW'(wq_mask[1]), DW'(16'h0000));
        check("t1_latency", DW'(wq_cyc[0] - t_b15), DW'(3));
        check("t1_len",     DW'(fd_len[0]), DW'(32));
        check("t1_bank",    DW'(fd_bank[0]), DW'(0));
        check("t1_ovf",     DW'(fd_ovf[0]), DW'(0));

        // 20-byte frame ending with the last byte: partial second beat
        clear_logs();
        start_frame();
        send_bytes(20, 8'h00, 1'b1, -1);
        wait_frames(1, 200);
        check("t2_nwrites", DW'(wq_addr.size()), DW'(2));
        check("t2_addr0",   DW'(wq_addr[0]), DW'(28'h100_0000));
        check("t2_addr1",   DW'(wq_addr[1]), DW'(28'h100_0008));
        check("t2_data1",   wq_data[1], 128'h10111213_00000000_00000000_00000000);
        check("t2_mask0",   DW'(wq_mask[0]), DW'(16'h0000));
        check("t2_mask1",   DW'(wq_mask[1]), DW'(M20));
        check("t2_len",     DW'(fd_len[0]), DW'(20));
        check("t2_bank",    DW'(fd_bank[0]), DW'(1));
        check("t2_done_lat", DW'(fd_cyc[0] - wq_cyc[1]), DW'(3));

        // Empty frame: no writes, done two cycles after frame_end
        clear_logs();
        start_frame();
        end_frame();
        wait_frames(1, 50);
        check("t3_nwrites", DW'(wq_addr.size()), DW'(0));
        check("t3_done_lat", DW'(fd_cyc[0] - t_fe), DW'(2));
        check("t3_len",     DW'(fd_len[0]), DW'(0));
        check("t3_bank",    DW'(fd_bank[0]), DW'(2));

        // Five one-byte frames: bank rotation with wrap
        do_reset();
        clear_logs();
        for (int b = 0; b < 5; b++) begin
            start_frame();
            send_bytes(1, 8'hA0 + 8'(b), 1'b1, -1);
            wait_frames(b + 1, 50);
        end
        check("t4_nwrites", DW'(wq_addr.size()), DW'(5));
        for (int b = 0; b < 5; b++) begin
            check("t4_bank", DW'(fd_bank[b]), DW'(b % 4));
            check("t4_addr", DW'(wq_addr[b]), DW'(28'(b % 4) << 24));
            check("t4_data", wq_data[b], {8'hA0 + 8'(b), 120'h0});
            check("t4_mask", DW'(wq_mask[b]), DW'(M1));
            check("t4_len",  DW'(fd_len[b]), DW'(1));
        end

        // Back-pressure and overflow: 320 bytes with cmd_ready low for 400 cycles
        do_reset();
        clear_logs();
        i_ddr3_cmd_ready = 1'b0;
        t_start = cyc;
        start_frame();
        send_bytes(320, 8'h00, 1'b1, -1);
        while (cyc < t_start + 400) step();
        check("t5_no_issue_while_low", DW'(wq_addr.size()), DW'(0));
        check("t5_ovf_live", DW'(o_overflow), DW'(1));
        check("t5_busy",     DW'(o_busy), DW'(1));
        i_ddr3_cmd_ready = 1'b1;
        wait_frames(1, 400);
        check("t5_nwrites", DW'(wq_addr.size()), DW'(16));
        check("t5_data0",   wq_data[0], ramp(8'h00));
        check("t5_data15",  wq_data[15], 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
        check("t5_addr15",  DW'(wq_addr[15]), DW'(28'h000_0078));
        check("t5_len",     DW'(fd_len[0]), DW'(320));
        check("t5_ovf_done", DW'(fd_ovf[0]), DW'(1));
        start_frame();
        check("t5_ovf_cleared", DW'(o_overflow), DW'(0));
        end_frame();
        wait_frames(2, 50);
        check("t5_no_extra", DW'(wq_addr.size()), DW'(16));

        // Reset mid-frame with three beats queued
        clear_logs();
        i_ddr3_cmd_ready = 1'b0;
        start_frame();
        send_bytes(48, 8'h00, 1'b0, -1);
        repeat (3) step();
        check("t6_busy_before", DW'(o_busy), DW'(1));
        rst_n = 1'b0;
        step();
        check("t6_busy",    DW'(o_busy), DW'(0));
        check("t6_addr",    DW'(o_ddr3_addr), DW'(0));
        check("t6_cmd_en",  DW'(o_ddr3_cmd_en), DW'(0));
        check("t6_wr_data", o_ddr3_wr_data, '0);
        check("t6_bank",    DW'(o_frame_bank), DW'(0));
        check("t6_done",    DW'(o_frame_done), DW'(0));
        rst_n = 1'b1;
        i_ddr3_cmd_ready = 1'b1;
        repeat (30) step();
        check("t6_no_writes", DW'(wq_addr.size()), DW'(0));
        check("t6_no_done",   DW'(fd_bank.size()), DW'(0));
        start_frame();
        send_bytes(16, 8'h30, 1'b1, -1);
        wait_frames(1, 100);
        check("t6_addr_after", DW'(wq_addr[0]), DW'(28'h000_0000));
        check("t6_data_after", wq_data[0], ramp(8'h30));
        check("t6_bank_after", DW'(fd_bank[0]), DW'(0));
        check("t6_len_after",  DW'(fd_len[0]), DW'(16));

        // frame_start pulsed mid-frame is ignored
        clear_logs();
        start_frame();
        send_bytes(32, 8'h00, 1'b0, 10);
        end_frame();
        wait_frames(1, 200);
        check("t7_nwrites", DW'(wq_addr.size()), DW'(2));
        check("t7_addr0",   DW'(wq_addr[0]), DW'(28'h100_0000));
        check("t7_addr1",   DW'(wq_addr[1]), DW'(28'h100_0008));
        check("t7_data1",   wq_data[1], ramp(8'h10));
        check("t7_len",     DW'(fd_len[0]), DW'(32));
        check("t7_bank",    DW'(fd_bank[0]), DW'(1));

        step();
        check("strobe_consistency", DW'(strobe_bad), DW'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
